// File: rtl/main_mem_responder.sv
// main_mem_responder
// ------------------
// Behavioural main memory behind the cache controller's memory port.
// It accepts one line-sized request at a time and answers after a fixed
// latency. It is used in simulation and FPGA bring-up.
//
// Parameters
//   DEPTH_LOG2 : storage holds 2**DEPTH_LOG2 lines of 128 bits
//   LATENCY    : cycles from request acceptance to ready (legal 1..255)
//
// Ports
//   clk       : sole clock; all logic runs on the rising edge
//   rst       : synchronous, active-high reset
//   mem_req   : request (addr, data, rw: 0=read 1=write, valid)
//   mem_data  : response (data, ready, valid)
//   proto_err : sticky protocol-violation flag
//
// Optional feature
//   MAIN_MEM_RESP_PROTO_CHECK_EN : when defined, flags a request that drops
//   valid or changes addr/rw while it is in service. When it is undefined,
//   proto_err is tied to 0.
//
// The storage array is not reset. Its lines hold X until they are written.

package main_mem_pkg;
    typedef struct packed {
        logic [31:0]  addr;
        logic [127:0] data;
        logic         rw;
        logic         valid;
    } mem_req_type;

    typedef struct packed {
        logic [127:0] data;
        logic         ready;
        logic         valid;
    } mem_data_type;
endpackage

module main_mem_responder
    import main_mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  mem_req_type  mem_req,
    output mem_data_type mem_data,
    output logic         proto_err
);

    localparam int         DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t          state_reg, state_next;
    logic [7:0]      cnt_reg, cnt_next;
    logic            load;
    logic            rd_en;
    logic            wr_en;

    // Latched request. This copy is used for the whole transaction.
    logic [31:0]     addr_reg;
    logic [127:0]    wdata_reg;
    logic            rw_reg;

    logic [127:0]    rdata_reg;
    logic [127:0]    mem_array [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic [DEPTH_LOG2-1:0] wr_idx;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 8'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        load       = 1'b0;
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (mem_req.valid) begin
                    load = 1'b1;
                    if (LATENCY == 1) begin
                        // No BUSY phase. The array is read on this edge
                        // using the live request address.
                        state_next = RESP;
                        cnt_next   = 8'd0;
                        rd_en      = ~mem_req.rw;
                    end else begin
                        state_next = BUSY;
                        cnt_next   = CNT_INIT;
                    end
                end
            end
            BUSY: begin
                cnt_next = cnt_reg - 8'd1;
                // The counter reaches 0 on this edge, so RESP follows.
                if (cnt_reg <= 8'd1) begin
                    state_next = RESP;
                    rd_en      = ~rw_reg;
                end
            end
            RESP: begin
                wr_en      = rw_reg;
                state_next = GAP;
            end
            GAP: begin
                // A request still held after ready is ignored here, so it
                // is not served a second time.
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch (datapath only, no reset needed)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (load) begin
            addr_reg  <= mem_req.addr;
            wdata_reg <= mem_req.data;
            rw_reg    <= mem_req.rw;
        end
    end

    // ------------------------------------------------------------------
    // Storage. Address bits [3:0] and those above the index are dropped,
    // so addresses alias modulo the array size.
    // ------------------------------------------------------------------
    assign rd_idx = (state_reg == IDLE) ? mem_req.addr[4 +: DEPTH_LOG2]
                                        : addr_reg[4 +: DEPTH_LOG2];
    assign wr_idx = addr_reg[4 +: DEPTH_LOG2];

    // A write whose RESP cycle coincides with reset is dropped.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem_array[wr_idx] <= wdata_reg;
        end
    end

    // Registered read port. It holds the last read line between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_reg <= 128'd0;
        end else if (rd_en) begin
            rdata_reg <= mem_array[rd_idx];
        end
    end

    assign mem_data.data  = rdata_reg;
    assign mem_data.ready = (state_reg == RESP);
    assign mem_data.valid = (state_reg == RESP) && !rw_reg;

    // ------------------------------------------------------------------
    // Protocol checker
    // ------------------------------------------------------------------
`ifdef MAIN_MEM_RESP_PROTO_CHECK_EN
    logic proto_err_reg;
    logic violation;

    assign violation = ((state_reg == BUSY) || (state_reg == RESP)) &&
                       (!mem_req.valid ||
                        (mem_req.addr != addr_reg) ||
                        (mem_req.rw != rw_reg));

    always_ff @(posedge clk) begin
        if (rst) begin
            proto_err_reg <= 1'b0;
        end else if (violation) begin
            proto_err_reg <= 1'b1;
        end
    end

    assign proto_err = proto_err_reg;
`else
    assign proto_err = 1'b0;
`endif

    // Address bits outside the line index are intentionally unused.
    logic unused_bits;
    assign unused_bits = ^{mem_req.addr, addr_reg};

endmodule

// File: tb/tb_main_mem_responder.sv
// Testbench for main_mem_responder.
// Two instances are used: one with LATENCY=4 and one with LATENCY=1.
// Both use DEPTH_LOG2=10. A behavioural model keeps line contents by index,
// the last returned read line, and the expected response latency.

module tb_main_mem_responder;
    import main_mem_pkg::*;

    localparam int LAT0 = 4;
    localparam int LAT1 = 1;
`ifdef MAIN_MEM_RESP_PROTO_CHECK_EN
    localparam bit PROTO_EXP = 1'b1;
`else
    localparam bit PROTO_EXP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    mem_req_type  req  [2];
    mem_data_type resp [2];
    logic         perr [2];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model
    logic [127:0] mdl_mem   [2][1024];
    bit           mdl_known [2][1024];
    logic [127:0] mdl_last  [2];
    bit           in_gap    [2];

    always #5 clk = ~clk;

    main_mem_responder #(.DEPTH_LOG2(10), .LATENCY(LAT0)) dut0 (
        .clk(clk), .rst(rst), .mem_req(req[0]), .mem_data(resp[0]), .proto_err(perr[0])
    );
    main_mem_responder #(.DEPTH_LOG2(10), .LATENCY(LAT1)) dut1 (
        .clk(clk), .rst(rst), .mem_req(req[1]), .mem_data(resp[1]), .proto_err(perr[1])
    );

    function automatic int lat_of(input int d);
        return (d == 0) ? LAT0 : LAT1;
    endfunction

    task automatic check_value(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int d, input int n);
        req[d].valid = 1'b0;
        repeat (n) step();
        in_gap[d] = 1'b0;
    endtask

    // Issue one request and hold it until ready. The task returns in the
    // GAP cycle with the request still held. If b2b is set and the DUT is
    // in GAP, the request is driven in GAP and served one cycle later.
    task automatic run_txn(input int d, input bit rw, input logic [31:0] addr,
                           input logic [127:0] wdata, input bit b2b);
        int exp_wait;
        int waited;
        bit seen;
        int idx;
        idx = int'(addr[13:4]);
        if (b2b && in_gap[d]) begin
            exp_wait = lat_of(d) + 1;
        end else begin
            req[d].valid = 1'b0;
            step();
            exp_wait = lat_of(d);
        end
        req[d].addr  = addr;
        req[d].data  = wdata;
        req[d].rw    = rw;
        req[d].valid = 1'b1;
        seen   = 1'b0;
        waited = 0;
        for (int c = 1; c <= exp_wait + 3; c++) begin
            step();
            if (resp[d].ready) begin
                seen   = 1'b1;
                waited = c;
                break;
            end
        end
        check_value("ready_seen", 128'(seen), 128'(1));
        check_value("latency", 128'(waited), 128'(exp_wait));
        if (seen) begin
            if (rw) begin
                check_value("wr_valid", 128'(resp[d].valid), 128'(0));
                check_value("wr_data_hold", resp[d].data, mdl_last[d]);
            end else begin
                check_value("rd_valid", 128'(resp[d].valid), 128'(1));
                check_value("rd_data", resp[d].data, mdl_mem[d][idx]);
                mdl_last[d] = mdl_mem[d][idx];
            end
            check_value("proto_quiet", 128'(perr[d]), 128'(0));
        end
        if (rw) begin
            mdl_mem[d][idx]   = wdata;
            mdl_known[d][idx] = 1'b1;
        end
        step();
        check_value("ready_gap", 128'(resp[d].ready), 128'(0));
        check_value("valid_gap", 128'(resp[d].valid), 128'(0));
        in_gap[d] = 1'b1;
        $display("txn dut%0d %s addr=%h wait=%0d exp=%0d", d, rw ? "WR" : "RD", addr, waited, exp_wait);
    endtask

    task automatic random_txn(input int d);
        int           line;
        bit           rw;
        logic [31:0]  addr;
        logic [127:0] data;
        bit           b2b;
        line = $urandom_range(0, 15);
        rw   = 1'($urandom_range(0, 1));
        if (!mdl_known[d][line]) rw = 1'b1;
        addr = ($urandom() & 32'hFFFF_C00F) | (32'(line) << 4);
        data = {$urandom(), $urandom(), $urandom(), $urandom()};
        b2b  = 1'($urandom_range(0, 1));
        run_txn(d, rw, addr, data, b2b);
    endtask

    logic [127:0] line_a;
    logic [127:0] line_b;

    initial begin
        for (int d = 0; d < 2; d++) begin
            req[d]      = '0;
            mdl_last[d] = '0;
            in_gap[d]   = 1'b0;
            for (int i = 0; i < 1024; i++) mdl_known[d][i] = 1'b0;
        end

        // Reset state
        repeat (3) step();
        for (int d = 0; d < 2; d++) begin
            check_value("rst_ready", 128'(resp[d].ready), 128'(0));
            check_value("rst_valid", 128'(resp[d].valid), 128'(0));
            check_value("rst_data", resp[d].data, 128'(0));
            check_value("rst_proto", 128'(perr[d]), 128'(0));
        end
        rst = 1'b0;
        step();

        // Directed write, then read of 0x40
        run_txn(0, 1'b1, 32'h0000_0040, 128'hDEADBEEF_01234567_89ABCDEF_00000001, 1'b0);
        run_txn(0, 1'b0, 32'h0000_0040, 128'd0, 1'b0);

        // Aliased write-back followed directly by an allocate read
        // (rw changes 1->0 in the GAP cycle)
        run_txn(0, 1'b1, 32'h0000_4040, 128'hCAFEF00D_11112222_33334444_55556666, 1'b0);
        run_txn(0, 1'b0, 32'h0000_0040, 128'd0, 1'b1);

        // Reset during a write: the write is discarded
        line_a = 128'hA5A5A5A5_00000000_12345678_9ABCDEF0;
        line_b = 128'h5A5A5A5A_FFFFFFFF_0BADF00D_0BADF00D;
        run_txn(0, 1'b1, 32'h0000_0080, line_a, 1'b0);
        idle(0, 1);
        req[0].addr  = 32'h0000_0080;
        req[0].data  = line_b;
        req[0].rw    = 1'b1;
        req[0].valid = 1'b1;
        step();
        check_value("busy_ready0", 128'(resp[0].ready), 128'(0));
        step();
        check_value("busy_ready1", 128'(resp[0].ready), 128'(0));
        rst          = 1'b1;
        req[0].valid = 1'b0;
        step();
        rst = 1'b0;
        check_value("rst_mid_ready", 128'(resp[0].ready), 128'(0));
        check_value("rst_mid_data", resp[0].data, 128'(0));
        check_value("rst_mid_proto", 128'(perr[0]), 128'(0));
        mdl_last[0] = '0;
        mdl_last[1] = '0;
        in_gap[0]   = 1'b0;
        in_gap[1]   = 1'b0;
        for (int c = 0; c < LAT0 + 2; c++) begin
            step();
            check_value("rst_no_ready", 128'(resp[0].ready), 128'(0));
        end
        run_txn(0, 1'b0, 32'h0000_0080, 128'd0, 1'b0);

        // Randomized traffic on the LATENCY=4 instance
        for (int i = 0; i < 40; i++) random_txn(0);
        idle(0, 1);

        // LATENCY=1: a back-to-back chain gives one response per 3 cycles
        run_txn(1, 1'b1, 32'h0000_0010, 128'h1, 1'b0);
        run_txn(1, 1'b1, 32'h0000_0020, 128'h2, 1'b1);
        run_txn(1, 1'b0, 32'h0000_0010, 128'd0, 1'b1);
        run_txn(1, 1'b0, 32'h0000_0020, 128'd0, 1'b1);
        for (int i = 0; i < 30; i++) random_txn(1);
        idle(1, 1);

        // Protocol check: address changes while BUSY
        idle(0, 1);
        req[0].addr  = 32'h0000_0040;
        req[0].rw    = 1'b0;
        req[0].valid = 1'b1;
        step();
        req[0].addr = 32'h0000_0050;
        step();
        check_value("proto_set", 128'(perr[0]), 128'(PROTO_EXP));
        begin
            bit seen;
            seen = 1'b0;
            for (int c = 0; c < LAT0 + 3; c++) begin
                if (resp[0].ready) begin
                    seen = 1'b1;
                    break;
                end
                step();
            end
            check_value("proto_ready", 128'(seen), 128'(1));
            // The latched address is used, not the changed one.
            if (seen) check_value("proto_rd_data", resp[0].data, mdl_mem[0][4]);
        end
        idle(0, 3);
        check_value("proto_held", 128'(perr[0]), 128'(PROTO_EXP));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_value("proto_clr", 128'(perr[0]), 128'(0));
        $display("txn dut0 PROTO addr change during BUSY");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
